// File: rtl/stack_pkg.sv
// Shared definitions for the stack unit and its drain reader: op codes, data width
// and the reader FSM state encoding.
package stack_pkg;

  localparam int unsigned WIDTH = 8;

  // Stack unit op codes
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_POP  = 3'b001;
  localparam logic [2:0] OP_PUSH = 3'b101;

  // Drain reader FSM states
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_SEND   = 3'd2;
  localparam logic [2:0] S_POP    = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

endpackage

// File: rtl/stack_drain_reader_stream_out_reg.sv
// Single-entry valid/ready holding register. A load captures new data and raises
// valid; valid drops on transfer. Data never changes while valid is held stalled.
module stream_out_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  // Capture on load, release valid on a completed transfer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stack_drain_reader.sv
// Read-side initiator that empties a stack unit: samples the top of stack, forwards it
// on a valid/ready stream, and only then pops it. Stops at empty or after `count` items
// (count == 0 drains until empty).
module stack_drain_reader #(
  parameter int unsigned WIDTH = stack_pkg::WIDTH,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic [WIDTH-1:0] dev_tail,
  input  logic             dev_empty,
  input  logic             dev_valid,
  output logic [WIDTH-1:0] dev_in,
  output logic [2:0]       dev_op,
  output logic             dev_apply
);

  import stack_pkg::*;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             unlimited_q, unlimited_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             apply_q, apply_d;
  logic [2:0]       op_q, op_d;
  logic             load;

  // The reader never pushes
  assign dev_in    = '0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dev_op    = op_q;
  assign dev_apply = apply_q;

  stream_out_reg #(
    .WIDTH (WIDTH)
  ) u_stream_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (dev_tail),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  // Next-state logic; registered outputs are set on entry to the state that shows them
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    unlimited_d = unlimited_q;
    err_d       = err_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    apply_d     = 1'b0;
    op_d        = OP_NOP;
    load        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          remaining_d = count;
          unlimited_d = (count == '0);
          err_d       = 1'b0;
          busy_d      = 1'b1;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (dev_empty || (!unlimited_q && remaining_q == '0)) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          load    = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        // Pop only after the value has been delivered, so a stall never loses data
        if (out_valid && out_ready) begin
          if (!unlimited_q && remaining_q != '0) begin
            remaining_d = remaining_q - CntOne;
          end
          apply_d = 1'b1;
          op_d    = OP_POP;
          state_d = S_POP;
        end
      end
      S_POP: begin
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (!dev_valid) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_CHECK;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      unlimited_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      apply_q     <= 1'b0;
      op_q        <= OP_NOP;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      unlimited_q <= unlimited_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      apply_q     <= apply_d;
      op_q        <= op_d;
    end
  end

endmodule

// File: tb/tb_stack_drain_reader.sv
// Bench for stack_drain_reader with a behavioural stack unit and a LIFO reference queue.
module tb_stack_drain_reader;
  import stack_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] count = '0;
  logic          busy, done, err;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  dev_tail;
  logic          dev_empty, dev_valid;
  logic [W-1:0]  dev_in;
  logic [2:0]    dev_op;
  logic          dev_apply;

  always #5 clk = ~clk;

  stack_drain_reader #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dev_tail  (dev_tail),
    .dev_empty (dev_empty),
    .dev_valid (dev_valid),
    .dev_in    (dev_in),
    .dev_op    (dev_op),
    .dev_apply (dev_apply)
  );

  // Behavioural stack unit (16 deep)
  logic [W-1:0] mem [16];
  logic [4:0]   sp = '0;
  logic         mv = 1'b1;
  logic         push_en = 1'b0;
  logic [W-1:0] push_data = '0;
  logic         stk_rst = 1'b0;
  logic         force_invalid = 1'b0;

  always @(posedge clk) begin
    if (stk_rst) begin
      sp <= '0;
      mv <= 1'b1;
    end else if (push_en) begin
      mem[sp[3:0]] <= push_data;
      sp <= sp + 5'd1;
      mv <= 1'b1;
    end else if (dev_apply && dev_op == OP_POP) begin
      if (sp == 5'd0) mv <= 1'b0;
      else begin
        sp <= sp - 5'd1;
        mv <= 1'b1;
      end
    end
  end

  assign dev_empty = (sp == 5'd0);
  assign dev_tail  = (sp == 5'd0) ? '0 : mem[4'(sp - 5'd1)];
  assign dev_valid = mv & ~force_invalid;

  // Reference contents (oldest first) and observed stream
  logic [W-1:0] ref_q[$];
  logic [W-1:0] got_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int apply_cnt = 0;
  int valid_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stream / pop monitor, plus data-hold check while stalled
  logic         pv = 1'b0, pr = 1'b0;
  logic [W-1:0] pd = '0;
  always @(negedge clk) begin
    if (!rst) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr && out_valid) chk("hold", 32'(out_data), 32'(pd));
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (dev_apply && dev_op == OP_POP) apply_cnt++;
      if (out_valid) valid_cnt++;
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] v);
    push_en   = 1'b1;
    push_data = v;
    tick();
    push_en = 1'b0;
    ref_q.push_back(v);
  endtask

  task automatic clear_stack();
    stk_rst = 1'b1;
    tick();
    stk_rst = 1'b0;
    ref_q.delete();
  endtask

  task automatic kick(input logic [CW-1:0] c);
    got_q.delete();
    apply_cnt = 0;
    valid_cnt = 0;
    start = 1'b1;
    count = c;
    tick();
    start = 1'b0;
  endtask

  // Returns at the negedge of the done cycle (or after the budget expires)
  task automatic wait_done(input int budget, input bit rnd_ready);
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (done) break;
      n++;
      if (n > budget) begin
        chk("done_timeout", 32'd0, 32'd1);
        break;
      end
      if (rnd_ready) begin
        @(posedge clk);
        #1 out_ready = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic wait_sig_valid(input int budget);
    int n = 0;
    while (!out_valid && n <= budget) begin
      @(negedge clk);
      n++;
    end
    chk("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  // Expected beats are the newest reference entries, newest first
  task automatic check_beats(input int n_exp);
    logic [W-1:0] e;
    chk("beat_count", 32'(got_q.size()), 32'(n_exp));
    for (int i = 0; i < n_exp; i++) begin
      if (ref_q.size() == 0) break;
      e = ref_q.pop_back();
      if (i < got_q.size()) chk("beat_data", 32'(got_q[i]), 32'(e));
    end
    got_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int c;
    int e;
    int guard;

    // Reset values
    stk_rst = 1'b1;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_apply", 32'(dev_apply), 32'd0);
    chk("rst_op", 32'(dev_op), 32'(OP_NOP));
    tick();
    rst = 1'b1;
    stk_rst = 1'b0;
    tick();

    // 1: full drain, count = 0
    clear_stack();
    push(8'h22); push(8'h44); push(8'h81);
    out_ready = 1'b1;
    kick(5'd0);
    wait_done(100, 1'b0);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_err", 32'(err), 32'd0);
    tick();
    chk("t1_busy_off", 32'(busy), 32'd0);
    chk("t1_done_pulse", 32'(done), 32'd0);
    check_beats(3);
    chk("t1_applies", 32'(apply_cnt), 32'd3);
    chk("t1_empty", 32'(dev_empty), 32'd1);
    chk("t1_dev_in", 32'(dev_in), 32'd0);

    // 2: count-limited drain leaves the rest
    clear_stack();
    for (int i = 0; i < 5; i++) push(8'($urandom));
    kick(5'd2);
    wait_done(100, 1'b0);
    tick();
    check_beats(2);
    chk("t2_left", 32'(sp), 32'd3);
    chk("t2_tail", 32'(dev_tail), 32'(ref_q[2]));

    // 3: start on an empty stack
    clear_stack();
    got_q.delete();
    apply_cnt = 0;
    valid_cnt = 0;
    start = 1'b1;
    count = 5'd4;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("t3_done_early", 32'(done), 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t3_done", 32'(done), 32'd1);
    tick();
    chk("t3_applies", 32'(apply_cnt), 32'd0);
    chk("t3_valids", 32'(valid_cnt), 32'd0);
    chk("t3_err", 32'(err), 32'd0);
    chk("t3_busy_off", 32'(busy), 32'd0);

    // 4: stalled consumer, data held and no pop before delivery
    clear_stack();
    push(8'h0A); push(8'h11);
    out_ready = 1'b0;
    kick(5'd0);
    wait_sig_valid(20);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t4_data", 32'(out_data), 32'(ref_q[1]));
      chk("t4_apply", 32'(dev_apply), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done(100, 1'b0);
    tick();
    check_beats(2);

    // 5: reset while in SEND, then drain again
    clear_stack();
    for (int i = 0; i < 3; i++) push(8'($urandom));
    out_ready = 1'b0;
    kick(5'd0);
    wait_sig_valid(20);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_data", 32'(out_data), 32'd0);
    chk("t5_apply", 32'(dev_apply), 32'd0);
    chk("t5_op", 32'(dev_op), 32'(OP_NOP));
    tick();
    rst = 1'b1;
    tick();
    out_ready = 1'b1;
    kick(5'd0);
    wait_done(100, 1'b0);
    tick();
    check_beats(3);
    chk("t5_applies", 32'(apply_cnt), 32'd3);

    // 6: stack unit rejects a pop
    clear_stack();
    push(8'h5C); push(8'hC5);
    out_ready = 1'b1;
    kick(5'd0);
    guard = 0;
    while (!dev_apply && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    force_invalid = 1'b1;
    wait_done(100, 1'b0);
    chk("t6_err", 32'(err), 32'd1);
    tick();
    force_invalid = 1'b0;
    chk("t6_busy_off", 32'(busy), 32'd0);
    chk("t6_err_sticky", 32'(err), 32'd1);
    check_beats(1);
    kick(5'd1);
    chk("t6_err_clr", 32'(err), 32'd0);
    wait_done(100, 1'b0);
    tick();
    check_beats(1);
    chk("t6_err_end", 32'(err), 32'd0);

    // Random loads, counts and consumer stalls
    for (int it = 0; it < 20; it++) begin
      clear_stack();
      n = int'($urandom_range(0, 6));
      for (int i = 0; i < n; i++) push(8'($urandom));
      c = int'($urandom_range(0, 7));
      kick(5'(c));
      wait_done(400, 1'b1);
      out_ready = 1'b1;
      chk("rnd_err", 32'(err), 32'd0);
      tick();
      e = (c == 0 || c > n) ? n : c;
      check_beats(e);
      chk("rnd_applies", 32'(apply_cnt), 32'(e));
      chk("rnd_left", 32'(sp), 32'(n - e));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
